// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate-block response checker: FSM states,
// response bit positions and the golden expected-vector function.
package gate_check_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int C_AND  = 0;
  localparam int C_OR   = 1;
  localparam int C_NAND = 2;
  localparam int C_NOR  = 3;
  localparam int C_XOR  = 4;
  localparam int C_XNOR = 5;
  localparam int C_NOTA = 6;

  function automatic logic [6:0] expected_vec(input logic a, input logic b);
    logic [6:0] e;
    e         = 7'd0;
    e[C_AND]  = a & b;
    e[C_OR]   = a | b;
    e[C_NAND] = ~(a & b);
    e[C_NOR]  = ~(a | b);
    e[C_XOR]  = a ^ b;
    e[C_XNOR] = ~(a ^ b);
    e[C_NOTA] = ~a;
    return e;
  endfunction

  function automatic logic [2:0] popcount7(input logic [6:0] m);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) begin
      n = n + {2'd0, m[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gate_golden.sv
// Combinational golden model of the two-input gate block.
module gate_golden
  import gate_check_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] expected
);

  assign expected = expected_vec(a, b);

endmodule

// File: rtl/gate_vector_checker.sv
// Drives all four (a,b) vectors into the gate block, compares its response
// against the golden model and reports pass/fail with a saturating error count.
module gate_vector_checker
  import gate_check_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [6:0]       resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic [6:0]       fail_mask
);

  localparam int SUM_W = ERR_W + 3;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [7:0]       hold_cnt;
  logic [1:0]       idx;
  logic             fail_seen;
  logic [6:0]       expected;
  logic [6:0]       mask;
  logic             sample;
  logic [SUM_W-1:0] sum;
  logic [ERR_W-1:0] err_next;

  gate_golden u_golden (
    .a        (idx[1]),
    .b        (idx[0]),
    .expected (expected)
  );

  assign mask   = resp ^ expected;
  assign sample = (state == S_RUN) && (hold_cnt == HOLD_LAST);
  assign sum    = {3'd0, err_count} + SUM_W'(popcount7(mask));
  assign err_next = (sum > {3'd0, ERR_MAX}) ? ERR_MAX : sum[ERR_W-1:0];

  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);
  assign a_out = (state == S_RUN) & idx[1];
  assign b_out = (state == S_RUN) & idx[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
        else       state_next = S_IDLE;
      end
      S_RUN: begin
        if (sample && (idx == 2'd3)) state_next = S_DONE;
        else                         state_next = S_RUN;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Vector sequencing, error accumulation and first-failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= 8'd0;
      idx       <= 2'd0;
      err_count <= '0;
      pass      <= 1'b0;
      fail_vec  <= 2'd0;
      fail_mask <= 7'd0;
      fail_seen <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      hold_cnt  <= 8'd0;
      idx       <= 2'd0;
      err_count <= '0;
      pass      <= 1'b0;
      fail_vec  <= 2'd0;
      fail_mask <= 7'd0;
      fail_seen <= 1'b0;
    end else if (sample) begin
      hold_cnt  <= 8'd0;
      idx       <= idx + 2'd1;
      err_count <= err_next;
      if ((mask != 7'd0) && !fail_seen) begin
        fail_vec  <= idx;
        fail_mask <= mask;
        fail_seen <= 1'b1;
      end
      if (idx == 2'd3) begin
        pass <= (err_next == '0);
      end
    end else if (state == S_RUN) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      hold_cnt <= hold_cnt;
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Self-checking bench: a model gate block with injectable faults feeds two
// checker instances; results are predicted from the gate truth rules.
module tb_gate_vector_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start0 = 1'b0, start1 = 1'b0;
  logic            a0, b0, a1, b1;
  logic [6:0]      resp0, resp1;
  logic            busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0]      err0;
  logic [3:0]      err1;
  logic [1:0]      fvec0, fvec1;
  logic [6:0]      fmask0, fmask1;
  logic [6:0]      keep0 = 7'h7F, keep1 = 7'h7F;
  logic [3:0][6:0] pert0 = '0, pert1 = '0;

  int checks = 0;
  int failures = 0;
  int cur_sel = 0;

  // Truth rules of the gate block, phrased with integer arithmetic.
  function automatic logic [6:0] gate_rule(input int a, input int b);
    logic [6:0] r;
    int s;
    s = a + b;
    r[0] = (a * b == 1);
    r[1] = (s > 0);
    r[2] = (a * b == 0);
    r[3] = (s == 0);
    r[4] = (s == 1);
    r[5] = (s != 1);
    r[6] = (a == 0);
    return r;
  endfunction

  assign resp0 = (gate_rule(int'(a0), int'(b0)) & keep0) ^ pert0[{a0, b0}];
  assign resp1 = (gate_rule(int'(a1), int'(b1)) & keep1) ^ pert1[{a1, b1}];

  gate_vector_checker #(.HOLD_CYCLES(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .resp(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_vec(fvec0), .fail_mask(fmask0)
  );

  gate_vector_checker #(.HOLD_CYCLES(1), .ERR_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .resp(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_vec(fvec1), .fail_mask(fmask1)
  );

  logic       o_busy, o_done, o_pass;
  logic [1:0] o_vec, o_fvec;
  logic [7:0] o_err;
  logic [6:0] o_fmask;
  assign o_busy  = (cur_sel == 1) ? busy1 : busy0;
  assign o_done  = (cur_sel == 1) ? done1 : done0;
  assign o_pass  = (cur_sel == 1) ? pass1 : pass0;
  assign o_vec   = (cur_sel == 1) ? {a1, b1} : {a0, b0};
  assign o_err   = (cur_sel == 1) ? {4'd0, err1} : err0;
  assign o_fvec  = (cur_sel == 1) ? fvec1 : fvec0;
  assign o_fmask = (cur_sel == 1) ? fmask1 : fmask0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (cur_sel == 1) start1 = v;
    else              start0 = v;
  endtask

  // Reference: score every vector against the truth rules, saturate, note first failure.
  task automatic predict(input logic [6:0] keep, input logic [3:0][6:0] pert, input int max_err,
                         output int err, output int fvec, output int fmask);
    logic [6:0] good, got, m;
    err = 0; fvec = -1; fmask = 0;
    for (int v = 0; v < 4; v++) begin
      good = gate_rule(v / 2, v % 2);
      got  = (good & keep) ^ pert[v];
      m    = got ^ good;
      err  = err + $countones(m);
      if (err > max_err) err = max_err;
      if (m != 7'd0 && fvec < 0) begin
        fvec = v; fmask = int'(m);
      end
    end
    if (fvec < 0) fvec = 0;
  endtask

  task automatic run_check(input int sel, input logic [6:0] keep, input logic [3:0][6:0] pert,
                           input int hold, input bit poke);
    int n, e_err, e_fvec, e_fmask, max_err;
    cur_sel = sel;
    max_err = (sel == 1) ? 15 : 255;
    @(negedge clk);
    if (sel == 1) begin keep1 = keep; pert1 = pert; end
    else          begin keep0 = keep; pert0 = pert; end
    predict(keep, pert, max_err, e_err, e_fvec, e_fmask);
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    n = 0;
    chk("busy_after_start", int'(o_busy), 1);
    while (n < 4 * hold + 8 && !o_done) begin
      if (n < 4 * hold) chk("vector", int'(o_vec), n / hold);
      set_start(poke && n == 3);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", n, 4 * hold);
    chk("done_pulse", int'(o_done), 1);
    chk("busy_at_done", int'(o_busy), 0);
    chk("vec_at_done", int'(o_vec), 0);
    chk("err_count", int'(o_err), e_err);
    chk("pass", int'(o_pass), (e_err == 0) ? 1 : 0);
    chk("fail_vec", int'(o_fvec), e_fvec);
    chk("fail_mask", int'(o_fmask), e_fmask);
    set_start(poke);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    chk("done_one_cycle", int'(o_done), 0);
    chk("no_restart", int'(o_busy), 0);
    @(posedge clk);
    @(negedge clk);
    chk("still_idle", int'(o_busy), 0);
    chk("err_hold", int'(o_err), e_err);
  endtask

  initial begin
    logic [3:0][6:0] pz, pinv, pr;
    int dcount;
    pz   = '0;
    pinv = {4{7'h7F}};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_ab", int'({a0, b0}), 0);
    rst = 1'b0;

    run_check(0, 7'h7F, pz, 4, 1'b1);
    chk("good_pass_lit", int'(pass0), 1);

    run_check(0, 7'h6F, pz, 4, 1'b0);
    chk("g_err_lit", int'(err0), 2);
    chk("g_fvec_lit", int'(fvec0), 1);
    chk("g_fmask_lit", int'(fmask0), 16);

    run_check(0, 7'h7F, pinv, 4, 1'b0);
    chk("inv_err_lit", int'(err0), 28);
    run_check(1, 7'h7F, pinv, 1, 1'b0);
    chk("sat_err_lit", int'(err1), 15);
    run_check(1, 7'h7F, pz, 1, 1'b1);
    chk("h1_pass_lit", int'(pass1), 1);

    for (int r = 0; r < 8; r++) begin
      for (int v = 0; v < 4; v++)
        pr[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127)) : 7'd0;
      run_check(r % 2, 7'h7F, pr, (r % 2 == 1) ? 1 : 4, 1'b0);
    end

    // Reset in the middle of a run after a failing check left results behind.
    run_check(0, 7'h7F, pinv, 4, 1'b0);
    cur_sel = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_ab", int'({a0, b0}), 0);
    chk("mid_rst_err", int'(err0), 0);
    chk("mid_rst_fvec", int'(fvec0), 0);
    chk("mid_rst_fmask", int'(fmask0), 0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done0 || busy0) dcount++;
    end
    chk("no_done_after_rst", dcount, 0);
    run_check(0, 7'h7F, pz, 4, 1'b0);
    chk("rerun_pass", int'(pass0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
